nioshello_mem_tester: RTL and testbench

//   Avalon-MM master that exercises a 32-bit on-chip memory slave: on start it writes a

---
 rtl/nioshello_mem_tester.sv | 156 +++++++++++++++
 tb/tb_nioshello_mem_tester.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nioshello_mem_tester.sv
// Avalon-MM memory tester. It writes seed+i over a word range, then reads the range
// back with up to MAX_PENDING outstanding reads, and reports pass, the error count and the first bad address.
`timescale 1ns/1ps
module nioshello_mem_tester #(
  parameter int AW          = 15,
  parameter int MAX_PENDING = 4,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW:0]      length,
  input  logic [31:0]      seed,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [AW-1:0]    first_err_addr,
  output logic [AW-1:0]    avm_address,
  output logic             avm_chipselect,
  output logic             avm_read,
  output logic             avm_write,
  output logic [31:0]      avm_writedata,
  output logic [3:0]       avm_byteenable,
  input  logic             avm_waitrequest,
  input  logic [31:0]      avm_readdata,
  input  logic             avm_readdatavalid
);
  localparam int PW = 4;
  localparam logic [PW-1:0]    PEND_MAX = PW'(MAX_PENDING);
  localparam logic [PW-1:0]    PEND_ONE = PW'(1);
  localparam logic [AW:0]      IDX_ONE  = (AW+1)'(1);
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    base_q;
  logic [AW:0]      len_q;
  logic [31:0]      seed_q;
  logic [AW:0]      wr_idx_q, wr_idx_d;
  logic [AW:0]      rd_idx_q, rd_idx_d;
  logic [AW:0]      rx_idx_q, rx_idx_d;
  logic [PW-1:0]    pend_q, pend_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [AW-1:0]    first_q, first_d;
  logic             pass_q, pass_d;

  logic        start_acc, wr_acc, rd_acc, rx;
  logic [31:0] rx_expect;

  // NOTE: bus requests are decoded from registered state only, never from
  // avm_waitrequest, so they are guaranteed stable while the slave stalls.
  assign avm_write      = (state_q == S_WRITE);
  assign avm_read       = (state_q == S_READ) && (rd_idx_q < len_q) && (pend_q < PEND_MAX);
  assign avm_chipselect = avm_read | avm_write;
  assign avm_byteenable = 4'b1111;
  assign avm_address    = avm_write ? base_q + wr_idx_q[AW-1:0] :
                          avm_read  ? base_q + rd_idx_q[AW-1:0] : '0;
  assign avm_writedata  = avm_write ? seed_q + 32'(wr_idx_q) : '0;

  assign busy           = (state_q == S_WRITE) || (state_q == S_READ);
  assign done           = (state_q == S_DONE);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;

  assign start_acc = (state_q == S_IDLE) && start;
  assign wr_acc    = avm_write & ~avm_waitrequest;
  assign rd_acc    = avm_read & ~avm_waitrequest;
  // Returns outside READ are stale beats from an aborted run.
  assign rx        = (state_q == S_READ) && avm_readdatavalid;
  assign rx_expect = seed_q + 32'(rx_idx_q);

  // NOTE: every variable gets its hold value first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    rx_idx_d = rx_idx_q;
    pend_d   = pend_q;
    err_d    = err_q;
    first_d  = first_q;
    pass_d   = pass_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          wr_idx_d = '0;
          rd_idx_d = '0;
          rx_idx_d = '0;
          pend_d   = '0;
          err_d    = '0;
          first_d  = '0;
          pass_d   = (length == '0);
          state_d  = (length == '0) ? S_DONE : S_WRITE;
        end
      end
      S_WRITE: begin
        if (wr_acc) begin
          wr_idx_d = wr_idx_q + IDX_ONE;
          if (wr_idx_d == len_q) state_d = S_READ;
        end
      end
      S_READ: begin
        if (rd_acc) rd_idx_d = rd_idx_q + IDX_ONE;
        pend_d = pend_q + (rd_acc ? PEND_ONE : '0) - (rx ? PEND_ONE : '0);
        if (rx) begin
          rx_idx_d = rx_idx_q + IDX_ONE;
          if (avm_readdata != rx_expect) begin
            if (err_q != '1) err_d = err_q + ERR_ONE;
            if (err_q == '0) first_d = base_q + rx_idx_q[AW-1:0];
          end
        end
        if ((rd_idx_d == len_q) && (pend_d == '0)) begin
          state_d = S_DONE;
          pass_d  = (err_d == '0);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: reset is synchronous; a reset mid-run drops every request on the next edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      seed_q   <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      rx_idx_q <= '0;
      pend_q   <= '0;
      err_q    <= '0;
      first_q  <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      rx_idx_q <= rx_idx_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
      first_q  <= first_d;
      pass_q   <= pass_d;
      if (start_acc) begin
        base_q <= base_addr;
        len_q  <= length;
        seed_q <= seed;
      end
    end
  end

endmodule

// File: tb/tb_nioshello_mem_tester.sv
// Self-checking bench for nioshello_mem_tester: behavioural RAM slave with latency,
// stalls and corruption, plus per-run expectations computed from the pattern rules.
`timescale 1ns/1ps
module tb_nioshello_mem_tester;
  localparam int AW    = 15;
  localparam int MAXP  = 4;
  localparam int ERR_W = 16;
  localparam int DEPTH = 1 << AW;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [AW-1:0]    base_addr = '0;
  logic [AW:0]      length = '0;
  logic [31:0]      seed = '0;
  logic             busy, done, pass;
  logic [ERR_W-1:0] err_count;
  logic [AW-1:0]    first_err_addr, avm_address;
  logic             avm_chipselect, avm_read, avm_write;
  logic [31:0]      avm_writedata;
  logic [3:0]       avm_byteenable;
  logic             avm_waitrequest = 1'b0;
  logic [31:0]      avm_readdata = '0;
  logic             avm_readdatavalid = 1'b0;

  nioshello_mem_tester #(.AW(AW), .MAX_PENDING(MAXP), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .length(length), .seed(seed), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // RAM slave model state
  logic [31:0] mem [DEPTH];
  logic [31:0] corrupt [int];
  typedef struct { longint due; logic [31:0] data; int gen; } rd_t;
  rd_t         rq [$];
  rd_t         ent;
  logic [AW-1:0] wr_addr_q [$];
  int     lat = 1;
  bit     stall_en = 1'b0;
  longint ncyc = 0;
  int     gen = 0;
  int     outstanding = 0, max_out = 0;
  int     wr_cnt = 0, rd_cnt = 0, rx_cnt = 0, act_cnt = 0, stray_cnt = 0;
  logic          prev_stall = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [31:0]   prev_data = '0, sd;

  // Slave works on the falling edge: DUT outputs are settled, and the inputs it
  // drives here are what the DUT samples on the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      if (!reset_n) begin
        gen++;
        outstanding = 0;
      end else begin
        checks++;
        if ((avm_read && avm_write) || (avm_chipselect !== (avm_read | avm_write)) ||
            (avm_byteenable !== 4'hF)) begin
          errors++;
          $display("FAIL bus_ctrl: rd=%b wr=%b cs=%b be=%h", avm_read, avm_write,
                   avm_chipselect, avm_byteenable);
        end
        if (outstanding > max_out) max_out = outstanding;
        if (outstanding >= MAXP) begin
          checks++;
          if (outstanding > MAXP || avm_read !== 1'b0) begin
            errors++;
            $display("FAIL pending_cap: outstanding=%0d avm_read=%b (need <=%0d and read=0)",
                     outstanding, avm_read, MAXP);
          end
        end
        if (prev_stall) begin
          checks++;
          if ({avm_read, avm_write, avm_address, avm_writedata} !==
              {prev_rd, prev_wr, prev_addr, prev_data}) begin
            errors++;
            $display("FAIL stall_hold: rd=%b wr=%b a=%h d=%h, held rd=%b wr=%b a=%h d=%h",
                     avm_read, avm_write, avm_address, avm_writedata,
                     prev_rd, prev_wr, prev_addr, prev_data);
          end
        end
      end
      avm_readdatavalid = 1'b0;
      avm_readdata      = $urandom;
      if (rq.size() > 0 && rq[0].due <= ncyc) begin
        ent = rq.pop_front();
        avm_readdatavalid = 1'b1;
        avm_readdata      = ent.data;
        if (ent.gen == gen) begin
          outstanding--;
          rx_cnt++;
        end else begin
          stray_cnt++;
        end
      end
      avm_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
      if (reset_n && avm_chipselect) act_cnt++;
      if (reset_n && avm_write && !avm_waitrequest) begin
        mem[avm_address] = avm_writedata;
        wr_addr_q.push_back(avm_address);
        wr_cnt++;
      end
      if (reset_n && avm_read && !avm_waitrequest) begin
        sd = mem[avm_address];
        if (corrupt.exists(int'(avm_address))) sd = sd ^ corrupt[int'(avm_address)];
        rq.push_back('{due: ncyc + longint'(lat), data: sd, gen: gen});
        outstanding++;
        rd_cnt++;
      end
      prev_stall = reset_n && (avm_read || avm_write) && avm_waitrequest;
      prev_rd    = avm_read;
      prev_wr    = avm_write;
      prev_addr  = avm_address;
      prev_data  = avm_writedata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete run; expectations derive from word i = seed+i at (base+i) mod 2^AW.
  task automatic run(input logic [AW-1:0] b, input logic [AW:0] n, input logic [31:0] s,
                     input int exp_cycles, input string name);
    int            exp_err, t0, bad;
    logic [AW-1:0] exp_first, a;
    bit            got;
    exp_err = 0;
    exp_first = '0;
    for (int k = 0; k < int'(n); k++) begin
      a = b + AW'(k);
      if (corrupt.exists(int'(a)) && corrupt[int'(a)] != 0) begin
        if (exp_err == 0) exp_first = a;
        exp_err++;
      end
    end
    wr_cnt = 0; rd_cnt = 0; rx_cnt = 0; act_cnt = 0; max_out = 0;
    wr_addr_q.delete();
    tick();
    start = 1'b1; base_addr = b; length = n; seed = s;
    t0 = cyc;
    got = 1'b0;
    tick();
    base_addr = AW'($urandom); length = (AW+1)'($urandom); seed = $urandom;
    for (int w = 0; w < 5000; w++) begin
      start = 1'b0;
      if (done) begin
        got = 1'b1;
        break;
      end
      if (w == 3) start = 1'b1;
      tick();
    end
    start = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout: done never seen within 5000 cycles", name);
      return;
    end
    if (exp_cycles >= 0) begin
      checks++;
      if (cyc - t0 != exp_cycles) begin
        errors++;
        $display("FAIL %s_latency: got %0d cycles, expected %0d", name, cyc - t0, exp_cycles);
      end
    end
    checks++;
    if ({busy, pass} !== {1'b0, exp_err == 0}) begin
      errors++;
      $display("FAIL %s_status: busy=%b pass=%b, expected busy=0 pass=%b", name, busy, pass,
               exp_err == 0);
    end
    checks++;
    if (err_count !== ERR_W'(exp_err) || first_err_addr !== exp_first) begin
      errors++;
      $display("FAIL %s_errors: err_count=%0d first=%h, expected %0d first=%h", name,
               err_count, first_err_addr, exp_err, exp_first);
    end
    checks++;
    if (wr_cnt != int'(n) || rd_cnt != int'(n) || rx_cnt != int'(n)) begin
      errors++;
      $display("FAIL %s_counts: writes=%0d reads=%0d returns=%0d, expected %0d each", name,
               wr_cnt, rd_cnt, rx_cnt, n);
    end
    bad = (wr_addr_q.size() != int'(n)) ? 1 : 0;
    for (int i = 0; i < wr_addr_q.size() && i < int'(n); i++) begin
      if (wr_addr_q[i] !== b + AW'(i)) bad++;
      if (mem[b + AW'(i)] !== s + 32'(i)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_pattern: %0d address/data mismatches in write stream", name, bad);
    end
    tick();
    checks++;
    if (done !== 1'b0 || pass !== (exp_err == 0)) begin
      errors++;
      $display("FAIL %s_after: done=%b pass=%b, expected done=0 pass=%b", name, done, pass,
               exp_err == 0);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({busy, done, pass, err_count, first_err_addr, avm_read, avm_write, avm_chipselect,
         avm_address, avm_writedata} !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b pass=%b err=%0d rd=%b wr=%b a=%h, expected all 0",
               busy, done, pass, err_count, avm_read, avm_write, avm_address);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    corrupt.delete(); lat = 1; stall_en = 1'b0;
    run(15'h0000, 16'd8, 32'h0000_0100, 18, "basic");
  endtask

  task automatic test_corrupt();
    corrupt.delete(); lat = 1; stall_en = 1'b0;
    corrupt[5] = 32'h0000_0001;
    corrupt[6] = 32'h8000_0000;
    run(15'h0000, 16'd8, $urandom, 18, "corrupt");
    corrupt.delete();
  endtask

  task automatic test_stall();
    corrupt.delete(); lat = 2; stall_en = 1'b1;
    run(AW'($urandom), 16'd32, $urandom, -1, "stall");
    stall_en = 1'b0;
  endtask

  task automatic test_pending();
    corrupt.delete(); lat = 6; stall_en = 1'b0;
    run(AW'($urandom), 16'd20, $urandom, -1, "pending");
    checks++;
    if (max_out != MAXP) begin
      errors++;
      $display("FAIL pending_peak: peak outstanding %0d, expected %0d", max_out, MAXP);
    end
  endtask

  task automatic test_wrap_empty();
    corrupt.delete(); lat = 1; stall_en = 1'b0;
    run(15'h7FFE, 16'd4, $urandom, 10, "wrap");
    run(AW'($urandom), 16'd0, $urandom, 1, "empty");
    checks++;
    if (act_cnt != 0) begin
      errors++;
      $display("FAIL empty_bus: %0d request cycles, expected 0", act_cnt);
    end
  endtask

  task automatic test_random();
    int n;
    logic [AW-1:0] b;
    for (int it = 0; it < 4; it++) begin
      corrupt.delete();
      lat = $urandom_range(1, 3);
      stall_en = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 40);
      b = AW'($urandom);
      if ($urandom_range(0, 1) == 1)
        corrupt[int'(b + AW'($urandom_range(0, n - 1)))] = 32'h1 << $urandom_range(0, 31);
      run(b, (AW+1)'(n), $urandom, stall_en ? -1 : 2 * n + lat + 1, "random");
    end
    corrupt.delete();
    stall_en = 1'b0;
  endtask

  task automatic test_reset_midrun();
    bit hit;
    corrupt.delete(); lat = 6; stall_en = 1'b0; stray_cnt = 0;
    tick();
    start = 1'b1; base_addr = AW'($urandom); length = 16'd16; seed = $urandom;
    tick();
    start = 1'b0;
    hit = 1'b0;
    for (int w = 0; w < 200; w++) begin
      if (rd_cnt >= 3 && outstanding >= 2) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL midrun_timeout: never reached READ with reads pending");
    end
    reset_n = 1'b0;
    tick();
    checks++;
    if ({busy, done, pass, err_count, first_err_addr, avm_read, avm_write, avm_chipselect,
         avm_address, avm_writedata} !== '0) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b done=%b rd=%b wr=%b a=%h, expected all 0",
               busy, done, avm_read, avm_write, avm_address);
    end
    reset_n = 1'b1;
    repeat (10) tick();
    checks++;
    if (stray_cnt == 0 || busy !== 1'b0 || done !== 1'b0 || err_count !== '0) begin
      errors++;
      $display("FAIL stray_ignored: strays=%0d busy=%b done=%b err=%0d, expected >0,0,0,0",
               stray_cnt, busy, done, err_count);
    end
    run(AW'($urandom), 16'd8, $urandom, -1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corrupt();
    test_stall();
    test_pending();
    test_wrap_empty();
    test_random();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
